srlatch_bank_ctrl: RTL and testbench
====================================

# srlatch_bank_ctrl

Sequencing controller and two-port arbiter for a WIDTH-bit bank of gated (clocked) SR latches. Two requesters submit set/clear masks; the block picks one round-robin and drives the bank's shared S/R/C lines through a safe setup -> enable pulse -> hold sequence. The bank never sees S=R=1 on any bit, and S/R never change while C is high. It sits between control logic and the latch bank and is the only driver of the bank's S, R and C inputs.

## Interface
- WIDTH, 8, number of latch bits in the bank
- PULSE_W, 2, cycles latch_c stays high per write; legal range 1..15
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request from requester i; held high until gnt[i]
- set_mask0 / set_mask1  in  WIDTH  bits to set, requester 0 / 1
- clr_mask0 / clr_mask1  in  WIDTH  bits to clear, requester 0 / 1
- gnt  out  2  one-cycle pulse: requester i won, masks captured
- done  out  2  one-cycle pulse: requester i's write finished
- err  out  1  one-cycle pulse with gnt: captured masks overlapped
- busy  out  1  high in every state except IDLE
- latch_s  out  WIDTH  bank S inputs
- latch_r  out  WIDTH  bank R inputs
- latch_c  out  1  bank enable (gate)

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD. All outputs are registered.
- IDLE:
  - latch_s = latch_r = 0, latch_c = 0.
  - If req is nonzero, choose the winner and capture its masks on the clock edge, then go to SETUP.
  - If req is zero, stay in IDLE.
- Arbitration:
  - A 1-bit priority pointer names the favoured requester.
  - If both requesters are active, the favoured one wins. A single active requester always wins.
  - After a grant, the pointer moves to the other requester.
- Captured values:
  - cap_s = set & ~clr
  - cap_r = clr & ~set
  - Bits set in both masks are held (0/0). If any bit is set in both masks, err pulses.
- SETUP (1 cycle):
  - latch_s = cap_s, latch_r = cap_r, latch_c = 0.
  - gnt[winner] = 1 and err is valid in this cycle.
- PULSE (PULSE_W cycles): latch_c = 1; latch_s and latch_r are unchanged. A down-counter tracks the duration.
- HOLD (1 cycle):
  - latch_c = 0; latch_s and latch_r are still held.
  - done[winner] = 1.
  - Next state is IDLE.
- req is ignored outside IDLE. A requester that keeps req high after its gnt is treated as a new request.
- Invariant: (latch_s & latch_r) == 0 in every cycle.
- Invariant: latch_s and latch_r change only when latch_c is 0, and the cycle before latch_c rises is not a change cycle.

## Timing
- Reset state (async, immediate):
  - state = IDLE, pointer = requester 0.
  - gnt, done, err, busy = 0.
  - latch_s, latch_r = 0; latch_c = 0.
  - Reset asserted mid-PULSE drops latch_c at once and abandons the write; no done is issued.
- Request sampled in IDLE at edge t:
  - t+1: SETUP, gnt, busy rises.
  - t+2 .. t+1+PULSE_W: latch_c high.
  - t+2+PULSE_W: HOLD, done.
  - t+3+PULSE_W: IDLE, latch_s and latch_r return to 0.
- Back-to-back throughput: one write per PULSE_W+3 cycles. A request pending at the return to IDLE enters SETUP on the next edge.
- Both requests arriving in the same cycle: one grant per write, alternating. Neither requester starves; worst-case wait is one full write.
- Mask changes after gnt have no effect.
- busy is high from SETUP through HOLD inclusive.

## Test plan
All scenarios use WIDTH=8, PULSE_W=2.
- Reset, then a single write: req=01, set_mask0=8'h0F, clr_mask0=8'hF0.
  - Next cycle: gnt=01, latch_s=0F, latch_r=F0, latch_c=0.
  - Then latch_c=1 for exactly 2 cycles.
  - Then HOLD with done=01, then IDLE with s=r=0. Total 5 cycles from the sampling edge.
- Simultaneous requests: req=11 held continuously.
  - Grants are 01, 10, 01, 10; a gnt every 5 cycles.
  - done[i] follows each gnt[i] by 3 cycles.
- Overlapping masks: set_mask1=8'hFF, clr_mask1=8'h0F.
  - err=1 together with gnt=10.
  - latch_s=F0, latch_r=00.
- Reset mid-operation: assert rst_n=0 in the second PULSE cycle.
  - latch_c, latch_s, latch_r, busy drop to 0 immediately; no done.
  - After release, req=11: gnt=01 (pointer was reset to requester 0).
- Invariant check: random masks and random req for 2000 cycles.
  - (latch_s & latch_r) is always 0.
  - latch_s and latch_r never change while latch_c=1 or on the cycle before latch_c rises.
  - gnt count equals done count.

Source files
------------

// File: rtl/srlatch_bank_ctrl.sv
// srlatch_bank_ctrl
//
// Sequencing controller and two-port round-robin arbiter for a WIDTH-bit bank of gated SR
// latches. A granted requester's set/clear masks are resolved into safe S/R values (bits named
// in both masks are held) and driven through setup -> enable pulse -> hold, so the bank never
// sees S=R=1 and S/R never move while the gate is open or about to open.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held until its gnt
//   set_mask0/1, clr_mask0/1   per-requester set / clear masks
//   gnt        one-cycle grant pulse (masks captured)
//   done       one-cycle completion pulse for the granted requester
//   err        one-cycle pulse with gnt when the captured masks overlapped
//   busy       high from SETUP through HOLD
//   latch_s/latch_r/latch_c    bank S, R and gate lines (all registered)
module srlatch_bank_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PULSE_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] set_mask0,
  input  logic [WIDTH-1:0] clr_mask0,
  input  logic [WIDTH-1:0] set_mask1,
  input  logic [WIDTH-1:0] clr_mask1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] latch_s,
  output logic [WIDTH-1:0] latch_r,
  output logic             latch_c
);

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  // Counter is loaded with PULSE_W-1 so the gate stays open exactly PULSE_W cycles.
  localparam logic [3:0] PulseLast = 4'(PULSE_W - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             win_q, win_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic             pick;
  logic [WIDTH-1:0] sel_set, sel_clr;

  // With both requesting, the pointer decides; a lone requester always wins.
  always_comb begin
    pick    = (req == 2'b11) ? ptr_q : req[1];
    sel_set = pick ? set_mask1 : set_mask0;
    sel_clr = pick ? clr_mask1 : clr_mask0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 1'b0;
    busy_d  = busy_q;
    c_d     = c_q;
    s_d     = s_q;
    r_d     = r_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StSetup;
          win_d       = pick;
          ptr_d       = ~pick;
          gnt_d[pick] = 1'b1;
          err_d       = |(sel_set & sel_clr);
          // Conflicting bits resolve to hold (S=R=0).
          s_d         = sel_set & ~sel_clr;
          r_d         = sel_clr & ~sel_set;
          busy_d      = 1'b1;
        end
      end
      StSetup: begin
        state_d = StPulse;
        c_d     = 1'b1;
        cnt_d   = PulseLast;
      end
      StPulse: begin
        if (cnt_q == 4'd0) begin
          state_d       = StHold;
          c_d           = 1'b0;
          done_d[win_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        // Gate already closed for a full cycle, so S/R may now return to zero.
        state_d = StIdle;
        s_d     = '0;
        r_d     = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        c_d     = 1'b0;
        s_d     = '0;
        r_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= 4'd0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      c_q     <= c_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign latch_s = s_q;
  assign latch_r = r_q;
  assign latch_c = c_q;

endmodule

// File: tb/tb_srlatch_bank_ctrl.sv
// Self-checking bench for srlatch_bank_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_srlatch_bank_ctrl;

  localparam int W  = 8;
  localparam int PW = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] set_mask0 = '0, clr_mask0 = '0, set_mask1 = '0, clr_mask1 = '0;
  logic [1:0]   gnt, done;
  logic         err, busy, latch_c;
  logic [W-1:0] latch_s, latch_r;

  srlatch_bank_ctrl #(.WIDTH(W), .PULSE_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .set_mask0 (set_mask0),
    .clr_mask0 (clr_mask0),
    .set_mask1 (set_mask1),
    .clr_mask1 (clr_mask1),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .latch_s   (latch_s),
    .latch_r   (latch_r),
    .latch_c   (latch_c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: one write = grant at offset 0, gate open offsets 1..PW, done at PW+1.
  bit           m_active = 1'b0;
  bit           m_ptr = 1'b0;
  bit           m_win = 1'b0;
  bit           m_err = 1'b0;
  int           m_off = 0;
  logic [W-1:0] m_s = '0, m_r = '0;

  logic         t_win;
  logic [W-1:0] t_set, t_clr;
  assign t_win = (req == 2'b11) ? m_ptr : req[1];
  assign t_set = t_win ? set_mask1 : set_mask0;
  assign t_clr = t_win ? clr_mask1 : clr_mask0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_ptr    <= 1'b0;
      m_off    <= 0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        m_active <= 1'b1;
        m_off    <= 0;
        m_win    <= t_win;
        m_ptr    <= !t_win;
        m_s      <= t_set & ~t_clr;
        m_r      <= t_clr & ~t_set;
        m_err    <= (t_set & t_clr) != '0;
      end
    end else begin
      if (m_off == PW + 1) m_active <= 1'b0;
      else m_off <= m_off + 1;
    end
  end

  logic [1:0]   exp_gnt, exp_done;
  logic         exp_err, exp_busy, exp_c;
  logic [W-1:0] exp_s, exp_r;
  assign exp_gnt  = (m_active && m_off == 0) ? (2'b01 << m_win) : 2'b00;
  assign exp_done = (m_active && m_off == PW + 1) ? (2'b01 << m_win) : 2'b00;
  assign exp_err  = m_active && m_off == 0 && m_err;
  assign exp_busy = m_active;
  assign exp_c    = m_active && m_off >= 1 && m_off <= PW;
  assign exp_s    = m_active ? m_s : '0;
  assign exp_r    = m_active ? m_r : '0;

  bit           prev_valid = 1'b0;
  logic         prev_c = 1'b0;
  logic [W-1:0] prev_s = '0, prev_r = '0;
  bit           count_en = 1'b0;
  int           n_gnt = 0, n_done = 0;

  always @(negedge clk) begin
    check("m_gnt", 32'(gnt), 32'(exp_gnt));
    check("m_done", 32'(done), 32'(exp_done));
    check("m_err", 32'(err), 32'(exp_err));
    check("m_busy", 32'(busy), 32'(exp_busy));
    check("m_latch_c", 32'(latch_c), 32'(exp_c));
    check("m_latch_s", 32'(latch_s), 32'(exp_s));
    check("m_latch_r", 32'(latch_r), 32'(exp_r));
    check("s_and_r_zero", 32'(latch_s & latch_r), 32'd0);
    if (prev_valid && rst_n && (prev_c || latch_c)) begin
      check("s_stable_gate", 32'(latch_s), 32'(prev_s));
      check("r_stable_gate", 32'(latch_r), 32'(prev_r));
    end
    prev_valid <= rst_n;
    prev_c     <= latch_c;
    prev_s     <= latch_s;
    prev_r     <= latch_r;
    if (count_en && gnt != 2'b00) n_gnt <= n_gnt + 1;
    if (count_en && done != 2'b00) n_done <= n_done + 1;
  end

  logic [1:0] g_val [4];
  int         g_cyc [4];
  int         ng;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_c", 32'(latch_c), 32'd0);
    check("rst_s", 32'(latch_s), 32'd0);
    rst_n = 1'b1;

    // Single write
    req = 2'b01; set_mask0 = 8'h0F; clr_mask0 = 8'hF0;
    tick();
    check("w1_gnt", 32'(gnt), 32'h1);
    check("w1_s", 32'(latch_s), 32'h0F);
    check("w1_r", 32'(latch_r), 32'hF0);
    check("w1_c_setup", 32'(latch_c), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    req = 2'b00;
    tick();
    check("w1_c_p1", 32'(latch_c), 32'd1);
    tick();
    check("w1_c_p2", 32'(latch_c), 32'd1);
    tick();
    check("w1_done", 32'(done), 32'h1);
    check("w1_c_hold", 32'(latch_c), 32'd0);
    check("w1_s_hold", 32'(latch_s), 32'h0F);
    tick();
    check("w1_idle_s", 32'(latch_s), 32'd0);
    check("w1_idle_r", 32'(latch_r), 32'd0);
    check("w1_idle_busy", 32'(busy), 32'd0);

    // Simultaneous requests from a fresh pointer
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req = 2'b11; set_mask0 = 8'h3C; clr_mask0 = 8'h00; set_mask1 = 8'h00; clr_mask1 = 8'hC3;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      tick();
      if (gnt != 2'b00) begin
        g_val[ng] = gnt;
        g_cyc[ng] = cyc;
        ng++;
      end
    end
    req = 2'b00;
    check("rr_count", 32'(ng), 32'd4);
    if (ng == 4) begin
      check("rr_g0", 32'(g_val[0]), 32'h1);
      check("rr_g1", 32'(g_val[1]), 32'h2);
      check("rr_g2", 32'(g_val[2]), 32'h1);
      check("rr_g3", 32'(g_val[3]), 32'h2);
      for (int i = 1; i < 4; i++) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
    end
    repeat (3) tick();
    check("rr_done_lag", 32'(done), 32'h2);
    repeat (2) tick();

    // Overlapping masks
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req = 2'b10; set_mask1 = 8'hFF; clr_mask1 = 8'h0F;
    tick();
    check("ov_err", 32'(err), 32'd1);
    check("ov_gnt", 32'(gnt), 32'h2);
    check("ov_s", 32'(latch_s), 32'hF0);
    check("ov_r", 32'(latch_r), 32'h00);
    req = 2'b00;
    repeat (5) tick();
    check("ov_idle", 32'(busy), 32'd0);

    // Reset during the second gate cycle
    req = 2'b01; set_mask0 = 8'hAA; clr_mask0 = 8'h55;
    tick();
    req = 2'b00;
    tick();
    tick();
    check("mr_c_before", 32'(latch_c), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_c", 32'(latch_c), 32'd0);
    check("mr_s", 32'(latch_s), 32'd0);
    check("mr_r", 32'(latch_r), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    req = 2'b11;
    tick();
    check("mr_ptr_reset", 32'(gnt), 32'h1);
    req = 2'b00;
    repeat (5) tick();

    // Random traffic
    count_en = 1'b1;
    repeat (2000) begin
      tick();
      req       = 2'($urandom_range(0, 3));
      set_mask0 = 8'($urandom);
      clr_mask0 = 8'($urandom);
      set_mask1 = 8'($urandom);
      clr_mask1 = 8'($urandom);
    end
    req = 2'b00;
    repeat (8) tick();
    count_en = 1'b0;
    tick();
    check("gnt_eq_done", 32'(n_gnt), 32'(n_done));
    check("gnt_seen", 32'(n_gnt != 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
